voice_mixer: RTL and testbench
==============================

// Module: voice_mixer
// PURPOSE
//  Time-multiplexes one shared multi-cycle multiplier across NUM_VOICES voices.
//  On each sample tick it reads every voice's sample and gain, multiplies them
//  in fixed point, and accumulates the products. It then emits one saturated
//  mixed sample. It sits directly upstream of the multiplier: it drives
//  a/b/trigger and consumes y/ready/done.
// PARAMETERS
//  C_WIDTH     32  sample, gain and product width; signed two's complement
//  FIXED_POINT 8   fraction bits of gain (documents scaling; multiplier does shift)
//  NUM_VOICES  8   voices mixed per tick, >=1
//  VSEL_W      3   voice index width, = max(1, clog2(NUM_VOICES))
// PORTS
//  ctl_clk      in   1        clock, all logic rising-edge
//  reset        in   1        asynchronous, active-high; clears all state
//  sample_tick  in   1        one-cycle pulse: start one mix pass
//  voice_sel    out  VSEL_W   voice being fetched
//  voice_sample in   C_WIDTH  sample of voice_sel; valid 1 cycle after voice_sel changes
//  voice_gain   in   C_WIDTH  gain of voice_sel, same timing as voice_sample
//  mul_a        out  C_WIDTH  multiplier operand a (sample)
//  mul_b        out  C_WIDTH  multiplier operand b (gain)
//  mul_trigger  out  1        one-cycle start pulse to the multiplier
//  mul_ready    in   1        multiplier idle; trigger legal only while high
//  mul_done     in   1        one-cycle pulse: mul_y valid this cycle
//  mul_y        in   C_WIDTH  product, already shifted by FIXED_POINT
//  mix_out      out  C_WIDTH  saturated mix; held until the next pass completes
//  mix_valid    out  1        one-cycle pulse when mix_out updates
//  busy         out  1        high from the cycle after an accepted tick until mix_valid
//  overrun      out  1        one-cycle pulse: sample_tick arrived while busy
// BEHAVIOUR
//  Reset values: all outputs 0. State IDLE, accumulator 0, voice index 0.
//  FSM:
//   IDLE  : sample_tick -> clear acc, idx=0, go FETCH.
//   FETCH : voice_sel=idx (1-cycle register-read latency) -> ISSUE.
//   ISSUE : latch mul_a=voice_sample and mul_b=voice_gain. mul_trigger=1 only
//           in the cycle mul_ready=1, then go WAIT. If mul_ready=0, stay; trigger stays 0.
//   WAIT  : hold operands; on mul_done capture mul_y -> ACC.
//   ACC   : acc += sign-extend(mul_y). If idx==NUM_VOICES-1 -> DONE,
//           else idx++ -> FETCH.
//   DONE  : mix_out=sat(acc), mix_valid=1 for this cycle only -> IDLE.
//  Accumulator: C_WIDTH+VSEL_W+1 bits signed, so it never overflows internally.
//  Saturation happens only at output: clamp to [-2^(C_WIDTH-1), 2^(C_WIDTH-1)-1].
//  Latency: multiplier trigger-to-done is L cycles and mul_ready is high. Then
//  tick to mix_valid = NUM_VOICES*(3+L)+2 cycles.
//  mul_trigger is never asserted in two consecutive cycles, and never outside ISSUE.
//  sample_tick while busy: tick is dropped, overrun pulses 1 cycle, current
//  pass is unaffected. A tick in the DONE cycle also counts as overrun.
//  mul_done outside WAIT is ignored.
//  Reset mid-pass (any state): async clear. mul_trigger and mix_valid drop at once.
//  mix_out returns to 0. No partial result is ever emitted.
//  voice_sel wraps never: idx range is 0..NUM_VOICES-1; the pass ends at the last voice.
// STRUCTURE
//  Shared package/header: FSM state localparams (IDLE, FETCH, ISSUE, WAIT, ACC,
//  DONE), clog2 function, and sat_signed(width) function reused by later stages.
//  One sub-module: mix_accumulator. It holds the signed accumulator with clear,
//  add-enable and the saturated output. The FSM stays in voice_mixer.
//  Integration: feed the multiplier with MUL_TYPE 1..3. The combinational type 0
//  needs a wrapper that produces ready/done.
// TESTING (C_WIDTH=32, FIXED_POINT=8, NUM_VOICES=4; bench multiplier model with L=4)
//  1. samples 0x100,0x200,0x300,0x400, gains 0x100, one tick
//     -> mix_out=0x00000A00, a single mix_valid pulse 30 cycles after the tick.
//  2. all samples 0x7FFFFF00, gains 0x100
//     -> mix_out=0x7FFFFFFF (positive saturation).
//  3. all samples 0x80000000, gains 0x100
//     -> mix_out=0x80000000 (negative clamp). Also samples 0x100, gains 0xFFFFFF00
//     -> mix_out=0xFFFFFC00.
//  4. second tick 5 cycles after the first
//     -> overrun pulses once; mix_out equals the case-1 value; exactly one mix_valid.
//  5. mul_ready held low 7 cycles in the first ISSUE
//     -> mul_trigger first rises in the cycle ready returns; result unchanged;
//        latency +7.
//  6. reset asserted during WAIT of voice 2
//     -> mul_trigger/busy/mix_valid=0 immediately, mix_out=0. The next tick after
//        release gives the correct case-1 result.

Source files
------------

// File: rtl/voice_mixer_pkg.sv
// Shared types and helpers for the voice mixer and later audio stages.
package voice_mixer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    ISSUE,
    WAIT,
    ACC,
    DONE
  } state_t;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r = r + 1;
    return r;
  endfunction

  // Clamp a wide signed value into the signed range of w bits (w <= 64).
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] x,
                                                    input int unsigned w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (x > hi) return hi;
    else if (x < lo) return lo;
    else return x;
  endfunction

endpackage

// File: rtl/mix_accumulator.sv
// Signed accumulator wide enough to never overflow; saturates only at its output.
module mix_accumulator
  import voice_mixer_pkg::*;
#(
  parameter int unsigned C_WIDTH = 32,
  parameter int unsigned ACC_W   = 36
) (
  input  logic               ctl_clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               add_en,
  input  logic [C_WIDTH-1:0] addend,
  output logic [C_WIDTH-1:0] sat_value
);

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] addend_ext;

  assign addend_ext = ACC_W'($signed(addend));

  always_ff @(posedge ctl_clk or posedge reset) begin
    if (reset)       acc <= '0;
    else if (clear)  acc <= '0;
    else if (add_en) acc <= acc + addend_ext;
  end

  assign sat_value = C_WIDTH'(sat_signed(64'(acc), C_WIDTH));

endmodule

// File: rtl/voice_mixer.sv
// Mixes NUM_VOICES voices per sample tick through one shared multi-cycle multiplier.
module voice_mixer
  import voice_mixer_pkg::*;
#(
  parameter int unsigned C_WIDTH     = 32,
  parameter int unsigned FIXED_POINT = 8,
  parameter int unsigned NUM_VOICES  = 8,
  parameter int unsigned VSEL_W      = (NUM_VOICES > 1) ? clog2(NUM_VOICES) : 1
) (
  input  logic               ctl_clk,
  input  logic               reset,
  input  logic               sample_tick,
  output logic [VSEL_W-1:0]  voice_sel,
  input  logic [C_WIDTH-1:0] voice_sample,
  input  logic [C_WIDTH-1:0] voice_gain,
  output logic [C_WIDTH-1:0] mul_a,
  output logic [C_WIDTH-1:0] mul_b,
  output logic               mul_trigger,
  input  logic               mul_ready,
  input  logic               mul_done,
  input  logic [C_WIDTH-1:0] mul_y,
  output logic [C_WIDTH-1:0] mix_out,
  output logic               mix_valid,
  output logic               busy,
  output logic               overrun
);

  localparam int unsigned       ACC_W = C_WIDTH + VSEL_W + 1;
  localparam logic [VSEL_W-1:0] LAST  = VSEL_W'(NUM_VOICES - 1);

  if (FIXED_POINT >= C_WIDTH || NUM_VOICES < 1) begin : g_param_check
    $error("voice_mixer: FIXED_POINT must be below C_WIDTH and NUM_VOICES >= 1");
  end

  state_t             state, state_next;
  logic [C_WIDTH-1:0] a_hold, b_hold, y_hold, sat_value;
  logic               acc_clear, acc_add;

  always_ff @(posedge ctl_clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Trigger is decoded combinationally so the multiplier starts in the ISSUE cycle itself.
  always_comb begin
    state_next  = state;
    acc_clear   = 1'b0;
    acc_add     = 1'b0;
    mul_trigger = 1'b0;
    case (state)
      IDLE: begin
        if (sample_tick) begin
          acc_clear  = 1'b1;
          state_next = FETCH;
        end
      end
      FETCH: state_next = ISSUE;
      ISSUE: begin
        if (mul_ready) begin
          mul_trigger = 1'b1;
          state_next  = WAIT;
        end
      end
      WAIT: if (mul_done) state_next = ACC;
      ACC: begin
        acc_add    = 1'b1;
        state_next = (voice_sel == LAST) ? DONE : FETCH;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge ctl_clk or posedge reset) begin
    if (reset) begin
      voice_sel <= '0;
      a_hold    <= '0;
      b_hold    <= '0;
      y_hold    <= '0;
      mix_out   <= '0;
      mix_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      mix_valid <= 1'b0;
      overrun   <= sample_tick && (state != IDLE);
      case (state)
        IDLE:  if (sample_tick) voice_sel <= '0;
        ISSUE: begin
          if (mul_ready) begin
            a_hold <= voice_sample;
            b_hold <= voice_gain;
          end
        end
        WAIT:  if (mul_done) y_hold <= mul_y;
        ACC:   if (voice_sel != LAST) voice_sel <= voice_sel + VSEL_W'(1);
        DONE: begin
          mix_out   <= sat_value;
          mix_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Operands follow the register file during ISSUE and are frozen once triggered.
  assign mul_a = (state == ISSUE) ? voice_sample : a_hold;
  assign mul_b = (state == ISSUE) ? voice_gain   : b_hold;
  assign busy  = (state != IDLE);

  mix_accumulator #(
    .C_WIDTH (C_WIDTH),
    .ACC_W   (ACC_W)
  ) u_acc (
    .ctl_clk   (ctl_clk),
    .reset     (reset),
    .clear     (acc_clear),
    .add_en    (acc_add),
    .addend    (y_hold),
    .sat_value (sat_value)
  );

endmodule

// File: tb/tb_voice_mixer.sv
// Scoreboard bench for voice_mixer with a register-file model and an L=4 multiplier model.
module tb_voice_mixer;

  localparam int unsigned CW = 32;
  localparam int unsigned FP = 8;
  localparam int unsigned NV = 4;
  localparam int unsigned VW = 2;
  localparam int          L  = 4;

  logic          ctl_clk = 1'b0;
  logic          reset;
  logic          sample_tick;
  logic [VW-1:0] voice_sel;
  logic [CW-1:0] voice_sample = '0;
  logic [CW-1:0] voice_gain = '0;
  logic [CW-1:0] mul_a, mul_b, mul_y, mix_out;
  logic          mul_trigger, mul_ready, mix_valid, busy, overrun;
  logic          mul_done = 1'b0;
  logic          ready_en;

  always #5 ctl_clk = ~ctl_clk;

  voice_mixer #(
    .C_WIDTH     (CW),
    .FIXED_POINT (FP),
    .NUM_VOICES  (NV),
    .VSEL_W      (VW)
  ) dut (
    .ctl_clk      (ctl_clk),
    .reset        (reset),
    .sample_tick  (sample_tick),
    .voice_sel    (voice_sel),
    .voice_sample (voice_sample),
    .voice_gain   (voice_gain),
    .mul_a        (mul_a),
    .mul_b        (mul_b),
    .mul_trigger  (mul_trigger),
    .mul_ready    (mul_ready),
    .mul_done     (mul_done),
    .mul_y        (mul_y),
    .mix_out      (mix_out),
    .mix_valid    (mix_valid),
    .busy         (busy),
    .overrun      (overrun)
  );

  logic [CW-1:0] samples [NV];
  logic [CW-1:0] gains   [NV];

  // Voice register file with one cycle of read latency.
  always @(posedge ctl_clk) begin
    voice_sample <= samples[voice_sel];
    voice_gain   <= gains[voice_sel];
  end

  function automatic logic [CW-1:0] fx_mul(input logic [CW-1:0] a, input logic [CW-1:0] b);
    logic signed [63:0] p;
    p = 64'($signed(a)) * 64'($signed(b));
    return CW'(p >>> FP);
  endfunction

  // Multiplier: done is high L cycles after the trigger cycle.
  int            mcnt = 0;
  logic [CW-1:0] prod = '0;
  always @(posedge ctl_clk) begin
    mul_done <= 1'b0;
    if (mul_trigger && mul_ready) begin
      prod <= fx_mul(mul_a, mul_b);
      mcnt <= L - 1;
    end else if (mcnt > 0) begin
      if (mcnt == 1) mul_done <= 1'b1;
      mcnt <= mcnt - 1;
    end
  end
  assign mul_y     = prod;
  assign mul_ready = ready_en && (mcnt == 0);

  int cyc = 0;
  always @(posedge ctl_clk) cyc <= cyc + 1;

  typedef struct {
    logic [CW-1:0] val;
    int            at;
  } exp_t;
  exp_t sb[$];

  int   checks = 0;
  int   fails = 0;
  int   ovr_cnt = 0;
  int   mv_cnt = 0;
  logic prev_trig = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge ctl_clk);
      if (mul_trigger) begin
        check("trigger_back_to_back", 64'(prev_trig), 64'd0);
        check("trigger_without_ready", 64'(mul_ready), 64'd1);
      end
      prev_trig = mul_trigger;
      if (overrun) ovr_cnt++;
      if (mix_valid) begin
        mv_cnt++;
        if (sb.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_mix_valid: mix_out 0x%0h at cycle %0d, no result expected",
                   mix_out, cyc);
        end else begin
          e = sb.pop_front();
          check("mix_out", 64'(mix_out), 64'(e.val));
          check("mix_latency_cycle", 64'(cyc), 64'(e.at));
        end
      end
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge ctl_clk);
      #1;
    end
  endtask

  task automatic fire(input logic [CW-1:0] val, input int extra, input bit expect_result);
    sample_tick = 1'b1;
    if (expect_result) sb.push_back('{val, cyc + 30 + extra});
    step(1);
    sample_tick = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      step(1);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      fails++;
      $display("FAIL drain: %0d results still outstanding after %0d cycles, expected 0",
               sb.size(), n);
      sb.delete();
    end
    step(2);
  endtask

  task automatic load(input logic [CW-1:0] s, input logic [CW-1:0] g, input bit ramp);
    for (int i = 0; i < int'(NV); i++) begin
      samples[i] = ramp ? CW'((i + 1) * 256) : s;
      gains[i]   = g;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish by 100000 time units");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    int ovr0, mv0;
    reset       = 1'b1;
    sample_tick = 1'b0;
    ready_en    = 1'b1;
    load('0, '0, 1'b0);
    fork
      monitor();
    join_none
    step(3);

    check("reset_mix_out", 64'(mix_out), 64'd0);
    check("reset_mix_valid", 64'(mix_valid), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_trigger", 64'(mul_trigger), 64'd0);
    check("reset_voice_sel", 64'(voice_sel), 64'd0);
    check("reset_overrun", 64'(overrun), 64'd0);
    check("reset_mul_a", 64'(mul_a), 64'd0);

    reset = 1'b0;
    step(2);

    // 1: ramp of samples at unity gain
    load('0, 32'h100, 1'b1);
    fire(32'h0000_0A00, 0, 1'b1);
    check("busy_after_tick", 64'(busy), 64'd1);
    drain();

    // 2: positive saturation
    load(32'h7FFF_FF00, 32'h100, 1'b0);
    fire(32'h7FFF_FFFF, 0, 1'b1);
    drain();

    // 3: negative clamp, then a small negative gain
    load(32'h8000_0000, 32'h100, 1'b0);
    fire(32'h8000_0000, 0, 1'b1);
    drain();
    load(32'h100, 32'hFFFF_FF00, 1'b0);
    fire(32'hFFFF_FC00, 0, 1'b1);
    drain();

    // 4: second tick 5 cycles into a pass is dropped
    load('0, 32'h100, 1'b1);
    ovr0 = ovr_cnt;
    mv0  = mv_cnt;
    fire(32'h0000_0A00, 0, 1'b1);
    step(4);
    sample_tick = 1'b1;
    step(1);
    sample_tick = 1'b0;
    drain();
    check("overrun_pulses", 64'(ovr_cnt - ovr0), 64'd1);
    check("mix_valid_pulses", 64'(mv_cnt - mv0), 64'd1);

    // 5: multiplier not ready for the first 7 ISSUE cycles
    ready_en = 1'b0;
    fire(32'h0000_0A00, 7, 1'b1);
    k = cyc - 1;
    while (cyc < k + 9) begin
      @(negedge ctl_clk);
      check("trigger_held_low", 64'(mul_trigger), 64'd0);
      step(1);
    end
    ready_en = 1'b1;
    #1;
    check("trigger_on_ready_return", 64'(mul_trigger), 64'd1);
    drain();

    // 6: reset in the WAIT of voice 2, then a clean pass
    fire('0, 0, 1'b0);
    step(17);
    check("pre_reset_voice_sel", 64'(voice_sel), 64'd2);
    check("pre_reset_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    check("midpass_reset_trigger", 64'(mul_trigger), 64'd0);
    check("midpass_reset_busy", 64'(busy), 64'd0);
    check("midpass_reset_mix_valid", 64'(mix_valid), 64'd0);
    check("midpass_reset_mix_out", 64'(mix_out), 64'd0);
    step(2);
    reset = 1'b0;
    step(10);
    fire(32'h0000_0A00, 0, 1'b1);
    drain();

    check("total_mix_valid", 64'(mv_cnt), 64'd7);
    check("total_overrun", 64'(ovr_cnt), 64'd1);
    step(3);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
